// File: rtl/bsg_vanilla_pkg.sv
// Shared barrier definitions: direction encoding, root destination constant
// and the safe clog2 helper used to size the destination index.
package bsg_vanilla_pkg;

    typedef enum logic [2:0] {
        e_bar_p  = 3'd0,
        e_bar_w  = 3'd1,
        e_bar_e  = 3'd2,
        e_bar_n  = 3'd3,
        e_bar_s  = 3'd4,
        e_bar_rw = 3'd5,
        e_bar_re = 3'd6
    } barrier_dir_e;

    localparam int barrier_root_dest_gp = 0;

    // clog2 that never returns 0, so a one-entry index still has a bit
    function automatic int safe_clog2(input int x);
        return (x == 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/vanilla_barrier_consensus.sv
// Parity-toggle consensus: out_r flips only when every masked source bit
// differs from it in the same cycle. An empty mask freezes out_r.
module vanilla_barrier_consensus
    import bsg_vanilla_pkg::*;
#(
    parameter int barrier_dirs_p = 7
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [barrier_dirs_p-1:0] mask_i,
    input  logic [barrier_dirs_p-1:0] in_i,
    output logic                      out_o
);

    logic                      out_r;
    logic [barrier_dirs_p-1:0] sel;
    logic                      all_diff;
    logic                      flip;

    // Flip decision: all selected bits must sit at the opposite parity of out_r
    always_comb begin
        sel      = mask_i & in_i;
        all_diff = out_r ? (sel == '0) : (sel == mask_i);
        flip     = (mask_i != '0) && all_diff;
    end

    // Consensus parity register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_r <= 1'b0;
        end else begin
            out_r <= out_r ^ flip;
        end
    end

    assign out_o = out_r;

endmodule

// File: rtl/vanilla_barrier_router.sv
// Per-tile barrier reduction/broadcast node. Samples Pi and the neighbour
// links, reduces the masked sources into a parity bit broadcast on link_o,
// and returns Po either from the local reduction (root) or from the parent
// link. Optional perf counters are built when VANILLA_BARRIER_PERF_EN is
// defined; otherwise both counter outputs are tied to zero.
module vanilla_barrier_router
    import bsg_vanilla_pkg::*;
#(
    parameter  int barrier_dirs_p     = 7,
    parameter  int perf_width_p       = 32,
    localparam int barrier_lg_dirs_lp = safe_clog2(barrier_dirs_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [barrier_dirs_p-1:0]     barrier_src_r_i,
    input  logic [barrier_lg_dirs_lp-1:0] barrier_dest_r_i,
    input  logic                          pi_i,
    input  logic [barrier_dirs_p-1:0]     link_i,
    output logic                          link_o,
    output logic                          po_o,
    output logic                          cfg_err_o,
    output logic [perf_width_p-1:0]       wait_cycles_o,
    output logic [perf_width_p-1:0]       barriers_done_o
);

    localparam int pad_w_lp = (1 << barrier_lg_dirs_lp) - barrier_dirs_p;
    localparam logic [barrier_lg_dirs_lp-1:0] dirs_lv_lp =
        barrier_lg_dirs_lp'(barrier_dirs_p);
    localparam logic [barrier_lg_dirs_lp-1:0] root_lv_lp =
        barrier_lg_dirs_lp'(barrier_root_dest_gp);

    logic [barrier_dirs_p-1:0]           in_r;
    logic [(1<<barrier_lg_dirs_lp)-1:0]  in_pad;
    logic                                out_r;
    logic                                po_r;
    logic                                po_n;
    logic                                cfg_err_r;
    logic                                dest_bad;
    logic                                dest_root;

    // Input stage: bit 0 carries the local Pi, link_i[0] is never looked at
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_r <= '0;
        end else begin
            in_r <= {link_i[barrier_dirs_p-1:1], pi_i};
        end
    end

    vanilla_barrier_consensus #(
        .barrier_dirs_p(barrier_dirs_p)
    ) consensus (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .mask_i (barrier_src_r_i),
        .in_i   (in_r),
        .out_o  (out_r)
    );

    // Po select: out-of-range destinations fall back to root behaviour
    always_comb begin
        in_pad    = {{pad_w_lp{1'b0}}, in_r};
        dest_bad  = (barrier_dest_r_i >= dirs_lv_lp);
        dest_root = (barrier_dest_r_i == root_lv_lp) || dest_bad;
        po_n      = dest_root ? out_r : in_pad[barrier_dest_r_i];
    end

    // Po register and sticky configuration error flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            po_r      <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            po_r      <= po_n;
            cfg_err_r <= cfg_err_r | dest_bad;
        end
    end

    assign link_o    = out_r;
    assign po_o      = po_r;
    assign cfg_err_o = cfg_err_r;

`ifdef VANILLA_BARRIER_PERF_EN
    logic [perf_width_p-1:0] wait_r;
    logic [perf_width_p-1:0] done_r;

    // Perf: saturating wait count while Pi and Po disagree, wrapping toggle count
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_r <= '0;
            done_r <= '0;
        end else begin
            if ((pi_i != po_r) && (wait_r != '1)) begin
                wait_r <= wait_r + 1'b1;
            end
            if (po_n != po_r) begin
                done_r <= done_r + 1'b1;
            end
        end
    end

    assign wait_cycles_o   = wait_r;
    assign barriers_done_o = done_r;
`else
    assign wait_cycles_o   = '0;
    assign barriers_done_o = '0;
`endif

endmodule
